// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronized line, runtime-prescaled oversampling with a
// 3-sample majority vote at mid-bit, optional parity, one stop bit.
//   IDLE   | line idle, waiting for a falling edge
//   START  | validating the start bit (glitch filter)
//   DATA   | shifting in data bits, LSB first
//   PARITY | checking the parity bit
//   STOP   | sampling the stop bit, leaves at mid-bit
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  Busy
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [PRESCALE_W-1:0] ONE      = 1;
  localparam logic [BW-1:0]         BIT_ONE  = 1;
  localparam logic [BW-1:0]         BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state, state_nxt;
  logic                    rx_meta, rx_s;
  logic [PRESCALE_W-1:0]   edge_cnt, presc_l, half;
  logic [BW-1:0]           bit_cnt;
  logic                    par_en_l, par_typ_l, par_bad;
  logic                    smp_a, smp_b;
  logic [DATA_WIDTH-1:0]   shreg;
  logic                    start_det, decide, wrap, bit_val, par_exp;

  assign half      = presc_l >> 1;
  assign start_det = (state == IDLE) && !rx_s;
  assign decide    = (state != IDLE) && (edge_cnt == half + ONE);
  assign wrap      = (state != IDLE) && (edge_cnt == presc_l - ONE);
  assign bit_val   = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
  assign par_exp   = par_typ_l ? ~^shreg : ^shreg;
  assign Busy      = (state != IDLE);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      state   <= IDLE;
    end else begin
      rx_meta <= RX_IN;
      rx_s    <= rx_meta;
      state   <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!rx_s) state_nxt = START;
      START: begin
        if (decide && bit_val) state_nxt = IDLE;
        else if (wrap)         state_nxt = DATA;
      end
      DATA:   if (wrap && bit_cnt == BIT_LAST) state_nxt = par_en_l ? PARITY : STOP;
      PARITY: if (wrap) state_nxt = STOP;
      STOP:   if (decide) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      edge_cnt   <= '0;
      presc_l    <= '0;
      bit_cnt    <= '0;
      par_en_l   <= 1'b0;
      par_typ_l  <= 1'b0;
      par_bad    <= 1'b0;
      smp_a      <= 1'b1;
      smp_b      <= 1'b1;
      shreg      <= '0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      if (start_det) begin
        edge_cnt  <= '0;
        bit_cnt   <= '0;
        presc_l   <= Prescale;
        par_en_l  <= PAR_EN;
        par_typ_l <= PAR_TYP;
        par_bad   <= 1'b0;
      end else if (state != IDLE) begin
        // Counter restarts whenever we drop back to IDLE at mid-bit.
        edge_cnt <= (wrap || (decide && state_nxt == IDLE)) ? '0 : edge_cnt + ONE;
        if (edge_cnt == half - ONE) smp_a <= rx_s;
        if (edge_cnt == half)       smp_b <= rx_s;
        if (decide) begin
          case (state)
            DATA:   shreg[bit_cnt] <= bit_val;
            PARITY: par_bad <= (bit_val != par_exp);
            STOP: begin
              if (bit_val && !par_bad) begin
                DATA_VALID <= 1'b1;
                P_DATA     <= shreg;
              end
              STP_ERR <= !bit_val;
              PAR_ERR <= par_bad;
            end
            default: ;
          endcase
        end
        if (state == DATA && wrap)
          bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are built from the line format, expected
// strobes and data are queued at issue time and checked by an independent monitor.
module tb_uart_rx;
  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic [7:0] P_DATA;
  logic       DATA_VALID, PAR_ERR, STP_ERR, Busy;

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK(CLK), .RST_n(RST_n), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .Prescale(Prescale), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] flags;   // {valid, par_err, stp_err}
    logic [7:0] data;
    longint     t0;
    longint     lat;
  } exp_t;

  exp_t       q[$];
  int         compared = 0;
  int         mismatched = 0;
  longint     cyc = 0;
  logic [7:0] model_last = 8'h00;

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    longint d;
    if (RST_n && (DATA_VALID || PAR_ERR || STP_ERR)) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_strobe: got %b expected none", {DATA_VALID, PAR_ERR, STP_ERR});
      end else begin
        e = q.pop_front();
        chk("strobes", {29'd0, DATA_VALID, PAR_ERR, STP_ERR}, {29'd0, e.flags});
        chk("p_data", {24'd0, P_DATA}, {24'd0, e.data});
        if (e.flags[2]) begin
          d = cyc - e.t0;
          compared++;
          if (d < e.lat - 1 || d > e.lat + 1) begin
            mismatched++;
            $display("FAIL latency: got %0d expected %0d +-1", d, e.lat);
          end
        end
      end
    end
  end

  function automatic int pick_presc();
    case ($urandom_range(0, 2))
      0: return 8;
      1: return 16;
      default: return 32;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int presc, input bit pe, input bit pt,
                            input bit bad_par, input bit bad_stop, input bit spike,
                            input bit scramble, input int abort_bit, input int gap);
    logic bits[$];
    logic pbit;
    exp_t e;
    PAR_EN = pe;
    PAR_TYP = pt;
    Prescale = presc[5:0];
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(d[k]);
    if (pe) begin
      pbit = (($countones(d) % 2) == 1) ^ pt;  // even: count incl. parity even
      bits.push_back(bad_par ? ~pbit : pbit);
    end
    bits.push_back(bad_stop ? 1'b0 : 1'b1);
    if (abort_bit < 0) begin
      e.flags[1] = pe && bad_par;
      e.flags[0] = bad_stop;
      e.flags[2] = !e.flags[1] && !e.flags[0];
      if (e.flags[2]) model_last = d;
      e.data = model_last;
      e.t0 = cyc;
      e.lat = 2 + presc * (9 + (pe ? 1 : 0)) + presc / 2 + 2;
      q.push_back(e);
    end
    for (int i = 0; i < bits.size(); i++) begin
      for (int c = 0; c < presc; c++) begin
        RX_IN = (spike && c == presc / 2) ? ~bits[i] : bits[i];
        if (scramble && i == 0 && c == 4) begin
          PAR_EN = 1'($urandom);
          PAR_TYP = 1'($urandom);
          Prescale = 6'(pick_presc());
        end
        if (i == abort_bit && c == presc / 2) begin
          RST_n = 1'b0;
          #1;
          chk("abort_p_data", {24'd0, P_DATA}, 32'd0);
          chk("abort_busy", {31'd0, Busy}, 32'd0);
          chk("abort_strobes", {29'd0, DATA_VALID, PAR_ERR, STP_ERR}, 32'd0);
          RX_IN = 1'b1;
          repeat (4) tick();
          RST_n = 1'b1;
          model_last = 8'h00;
          repeat (3 * presc) tick();
          return;
        end
        tick();
      end
    end
    RX_IN = 1'b1;
    repeat (gap) tick();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q.size() != 0 || Busy) && n < 4000) begin
      tick();
      n++;
    end
    if (n >= 4000) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, q.size());
    end
  endtask

  initial begin
    int busy_cnt;
    int p;
    bit pe;
    repeat (3) tick();
    chk("rst_p_data", {24'd0, P_DATA}, 32'd0);
    chk("rst_strobes", {29'd0, DATA_VALID, PAR_ERR, STP_ERR}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    RST_n = 1'b1;
    repeat (5) tick();

    send_frame(8'hA5, 8, 0, 0, 0, 0, 0, 0, -1, 16);
    drain("a5");
    chk("a5_held", {24'd0, P_DATA}, 32'hA5);

    send_frame(8'h3C, 16, 1, 0, 0, 0, 0, 0, -1, 32);
    send_frame(8'h3C, 16, 1, 0, 1, 0, 0, 0, -1, 32);
    drain("par");

    send_frame(8'h01, 8, 1, 1, 0, 1, 0, 0, -1, 16);
    send_frame(8'h7E, 8, 0, 0, 0, 0, 0, 0, -1, 16);
    drain("stp");

    Prescale = 6'd8;
    RX_IN = 1'b0;
    repeat (2) tick();
    RX_IN = 1'b1;
    busy_cnt = 0;
    repeat (24) begin
      @(negedge CLK);
      if (Busy) busy_cnt++;
    end
    tick();
    chk("glitch_busy_le_presc", {31'd0, (busy_cnt > 0 && busy_cnt <= 8)}, 32'd1);
    chk("glitch_busy_end", {31'd0, Busy}, 32'd0);
    chk("glitch_p_data", {24'd0, P_DATA}, 32'h7E);

    send_frame(8'h55, 32, 0, 0, 0, 0, 1, 0, -1, 0);
    send_frame(8'hAA, 32, 0, 0, 0, 0, 1, 0, -1, 64);
    drain("b2b");

    send_frame(8'h96, 8, 0, 0, 0, 0, 0, 0, -1, 16);
    drain("pre_abort");
    send_frame(8'h11, 8, 0, 0, 0, 0, 0, 0, 5, 0);
    chk("post_abort_busy", {31'd0, Busy}, 32'd0);
    send_frame(8'hC3, 8, 0, 0, 0, 0, 0, 0, -1, 16);
    drain("c3");

    for (int n = 0; n < 24; n++) begin
      p = pick_presc();
      pe = 1'($urandom);
      send_frame(8'($urandom), p, pe, 1'($urandom), pe && ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0), 1'($urandom), 1'b1, -1, 2 * p);
    end
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver. Sits directly downstream of the UART transmitter and consumes its serial line.
- Recovers 8-bit frames: start bit, 8 data bits LSB-first, optional parity, one stop bit.
- Oversamples the line by a runtime prescale and takes a majority vote at mid-bit.
- Presents the parallel byte with a one-cycle valid strobe plus parity and framing error flags.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESCALE_W, 6, width of the Prescale input.

Ports:
- CLK  input  1  receiver clock, Prescale times the line bit rate.
- RST_n  input  1  asynchronous active-low reset.
- RX_IN  input  1  serial line; idle high; asynchronous to CLK.
- PAR_EN  input  1  1 = frame carries a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity (same convention as the transmitter).
- Prescale  input  PRESCALE_W  CLK cycles per bit; supported values 8, 16, 32.
- P_DATA  output  DATA_WIDTH  last correctly received byte.
- DATA_VALID  output  1  one-cycle strobe: P_DATA has been updated.
- PAR_ERR  output  1  one-cycle strobe: parity mismatch in the frame just ended.
- STP_ERR  output  1  one-cycle strobe: stop bit sampled low.
- Busy  output  1  high while a frame is being received.

Behaviour:
- Reset values:
  - P_DATA = 0; DATA_VALID, PAR_ERR, STP_ERR, Busy = 0.
  - FSM = IDLE; all counters 0; synchronizer flops = 1.
  - Reset asserted mid-frame aborts the frame immediately; no strobe is produced.
- Input path: RX_IN passes through a 2-FF synchronizer; rx_s is the second-flop output. All behaviour below refers to rx_s.
- Counters:
  - edge_cnt counts 0..Prescale-1 within each bit period, then wraps to 0.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- Sampling:
  - rx_s is captured at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1.
  - The bit value is the majority of the three captures, decided on the cycle edge_cnt = Prescale/2+1.
- Configuration: PAR_EN, PAR_TYP and Prescale are latched when the start edge is detected. Changes mid-frame have no effect until the next frame.
- FSM states and transitions:
  - IDLE: on rx_s = 0 -> START with edge_cnt = 0; Busy rises on the next cycle.
  - START: at the mid-bit decision, a sampled 1 (glitch) -> IDLE with no strobe and Busy dropping. A sampled 0 -> DATA at edge_cnt wrap.
  - DATA: bit bit_cnt is written to shift register position bit_cnt (LSB first). After bit DATA_WIDTH-1 wraps: PAR_EN = 1 -> PARITY, else -> STOP.
  - PARITY: the decided bit is compared with the expected value: ^data for even, ~^data for odd. The mismatch is held in par_bad. -> STOP at wrap.
  - STOP: on the mid-bit decision cycle -> IDLE without waiting for the wrap, so back-to-back frames are caught.
- End-of-frame outputs, on the cycle after the stop decision:
  - stop = 1 and par_bad = 0: DATA_VALID = 1 and P_DATA loaded.
  - stop = 0: STP_ERR = 1.
  - par_bad = 1: PAR_ERR = 1.
  - DATA_VALID never coincides with either error strobe.
  - On error, P_DATA keeps its previous value.
  - Busy falls on this same cycle.
- All strobes are exactly one cycle wide.
- Line held low in IDLE after a framing error: treated as a new start edge. A frame that is stuck low ends with STP_ERR.
- Latency: the DATA_VALID rising edge occurs 2 (synchronizer) + Prescale*(1 + DATA_WIDTH + PAR_EN) + Prescale/2 + 2 cycles after the RX_IN falling edge, ±1 cycle.

Test Plan:
- Prescale = 8, PAR_EN = 0, send 0xA5 with a valid stop bit -> one DATA_VALID pulse, P_DATA = 0xA5, no error strobes.
- Prescale = 16, PAR_EN = 1, PAR_TYP = 0:
  - Send 0x3C with parity bit 0 -> DATA_VALID, P_DATA = 0x3C.
  - Repeat with parity bit 1 -> PAR_ERR pulse only, P_DATA stays 0x3C.
- Prescale = 8, odd parity, send 0x01 with stop bit forced 0 -> STP_ERR pulse, no DATA_VALID; the next valid frame 0x7E is received correctly.
- Start glitch: RX_IN low for 2 CLK only -> no strobes; Busy high for at most Prescale cycles, then returns to 0.
- Frames 0x55 and 0xAA back-to-back with no idle gap, Prescale = 32 -> two DATA_VALID pulses with P_DATA 0x55 then 0xAA. Also inject a 1-CLK inverted spike at each mid-bit edge -> data unaffected by the majority vote.
- Assert RST_n low during data bit 4 -> outputs 0 immediately; after release, the next frame 0xC3 is received correctly.
